// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU definitions: ALU operation codes (common with decoder/ALU)
// and the HI/LO unit state encoding.
package mips_cpu_pkg;

    typedef enum logic [4:0] {
        AluMul  = 5'd2,
        AluDiv  = 5'd3,
        AluMulu = 5'd22,
        AluDivu = 5'd23,
        AluMthi = 5'd24,
        AluMtlo = 5'd25
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StDiv,
        StFix
    } hilo_state_e;

endpackage

// File: rtl/mips_cpu_hilo_muldiv_if.sv
// Datapath <-> HI/LO unit signal bundle. The datapath drives the master side.
interface mips_cpu_hilo_muldiv_if;

    logic        instr_valid;
    logic        spc_reg_write_en;
    logic [4:0]  alu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    modport master (
        output instr_valid, spc_reg_write_en, alu_op, src_a, src_b,
        input  hi, lo, busy
    );

    modport slave (
        input  instr_valid, spc_reg_write_en, alu_op, src_a, src_b,
        output hi, lo, busy
    );

endinterface

// File: rtl/mips_cpu_divider_core.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first.
// o_done is high during the final iteration cycle.
module mips_cpu_divider_core #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_done,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_div;
    logic [4:0]  r_cnt;
    logic        r_active;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_last;

    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_last  = (r_cnt == 5'(DIV_CYCLES - 1));

    // A restored remainder is always below the divisor, so 32 bits hold it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_rem    <= '0;
            r_quo    <= i_dividend;
            r_div    <= i_divisor;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_cnt <= r_cnt + 5'd1;
            if (w_last) begin
                r_active <= 1'b0;
            end
            if (w_diff[32]) begin
                r_rem <= w_shift[31:0];
                r_quo <= {r_quo[30:0], 1'b0};
            end else begin
                r_rem <= w_diff[31:0];
                r_quo <= {r_quo[30:0], 1'b1};
            end
        end
    end

    assign o_done      = r_active & w_last;
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/mips_cpu_hilo_muldiv.sv
// HI/LO special-register unit: single-cycle MULT/MULTU, MTHI/MTLO, and a
// 33-cycle iterative DIV/DIVU with a Busy stall to the datapath.
module mips_cpu_hilo_muldiv
    import mips_cpu_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    mips_cpu_hilo_muldiv_if.slave bus
);

    hilo_state_e r_state, w_state_d;
    logic        r_busy;
    logic [31:0] r_hi, r_lo;
    logic        r_q_neg, r_r_neg, r_div_zero;

    logic        w_issue, w_is_div, w_signed, w_start, w_done;
    logic [4:0]  w_op;
    logic [63:0] w_ext_a, w_ext_b, w_prod;
    logic [31:0] w_mag_a, w_mag_b;
    logic [31:0] w_quo, w_rem, w_quo_fix, w_rem_fix;

    assign w_op     = bus.alu_op;
    assign w_issue  = bus.instr_valid & bus.spc_reg_write_en & ~r_busy;
    assign w_is_div = (w_op == AluDiv) || (w_op == AluDivu);
    assign w_signed = (w_op == AluMul) || (w_op == AluDiv);

    // Low 64 bits of the extended product give both signed and unsigned results.
    assign w_ext_a = {{32{w_signed & bus.src_a[31]}}, bus.src_a};
    assign w_ext_b = {{32{w_signed & bus.src_b[31]}}, bus.src_b};
    assign w_prod  = w_ext_a * w_ext_b;

    assign w_mag_a = (w_signed & bus.src_a[31]) ? -bus.src_a : bus.src_a;
    assign w_mag_b = (w_signed & bus.src_b[31]) ? -bus.src_b : bus.src_b;

    mips_cpu_divider_core #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_divider_core (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (w_start),
        .i_dividend  (w_mag_a),
        .i_divisor   (w_mag_b),
        .o_done      (w_done),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    // On divide-by-zero the core returns |SrcA| as remainder; negating it when
    // SrcA was negative reproduces SrcA exactly, so Hi always equals SrcA.
    assign w_quo_fix = r_div_zero ? 32'hFFFF_FFFF : (r_q_neg ? -w_quo : w_quo);
    assign w_rem_fix = r_r_neg ? -w_rem : w_rem;

    always_comb begin
        w_state_d = r_state;
        w_start   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_issue && w_is_div) begin
                    w_start   = 1'b1;
                    w_state_d = StDiv;
                end
            end
            StDiv:   if (w_done) w_state_d = StFix;
            StFix:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_busy     <= 1'b0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_busy  <= (w_state_d != StIdle);
            if (w_start) begin
                r_q_neg    <= w_signed & (bus.src_a[31] ^ bus.src_b[31]);
                r_r_neg    <= w_signed & bus.src_a[31];
                r_div_zero <= (bus.src_b == 32'd0);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == StFix) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
        end else if (w_issue) begin
            case (w_op)
                AluMul, AluMulu: {r_hi, r_lo} <= w_prod;
                AluMthi:         r_hi <= bus.src_a;
                AluMtlo:         r_lo <= bus.src_a;
                default:         ;
            endcase
        end
    end

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = r_busy;

endmodule

// File: tb/tb_mips_cpu_hilo_muldiv.sv
// Self-checking bench for the HI/LO unit: directed cases plus random ops
// against an arithmetic reference model of HI/LO.
module tb_mips_cpu_hilo_muldiv;
    import mips_cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    mips_cpu_hilo_muldiv_if u_if ();

    mips_cpu_hilo_muldiv #(
        .DIV_CYCLES (32)
    ) u_dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (u_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic.
    function automatic void model_apply(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            AluMul: begin
                p = sa * sb;
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            AluMulu: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            AluDiv, AluDivu: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else if (op == AluDiv) begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            AluMthi: m_hi = a;
            AluMtlo: m_lo = a;
            default: ;
        endcase
    endfunction

    // Issue one op on an idle unit, follow it to completion and check HI/LO.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int   cyc;
        logic held;
        @(negedge clk);
        u_if.instr_valid      = 1'b1;
        u_if.spc_reg_write_en = 1'b1;
        u_if.alu_op           = op;
        u_if.src_a            = a;
        u_if.src_b            = b;
        @(posedge clk);
        #1;
        u_if.instr_valid = 1'b0;
        if (op == AluDiv || op == AluDivu) begin
            cyc  = 0;
            held = 1'b1;
            while (u_if.busy === 1'b1 && cyc < 40) begin
                if (u_if.hi !== m_hi || u_if.lo !== m_lo) held = 1'b0;
                cyc++;
                @(posedge clk);
                #1;
            end
            check({tag, "_busy_cycles"}, cyc, 33);
            check({tag, "_held"}, {31'd0, held}, 32'd1);
        end else begin
            check({tag, "_busy"}, {31'd0, u_if.busy}, 32'd0);
        end
        model_apply(op, a, b);
        check({tag, "_hi"}, u_if.hi, m_hi);
        check({tag, "_lo"}, u_if.lo, m_lo);
    endtask

    initial begin
        logic [4:0]  ops [6];
        logic [31:0] ra, rb;
        int          cyc;
        ops = '{AluMul, AluMulu, AluDiv, AluDivu, AluMthi, AluMtlo};

        u_if.instr_valid      = 1'b0;
        u_if.spc_reg_write_en = 1'b0;
        u_if.alu_op           = '0;
        u_if.src_a            = '0;
        u_if.src_b            = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hi", u_if.hi, 32'd0);
        check("reset_lo", u_if.lo, 32'd0);
        check("reset_busy", {31'd0, u_if.busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mul_neg", AluMul, 32'hFFFF_FFFD, 32'd5);
        check("mul_neg_hi_const", u_if.hi, 32'hFFFF_FFFF);
        check("mul_neg_lo_const", u_if.lo, 32'hFFFF_FFF1);
        run_op("mulu_max", AluMulu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulu_max_hi_const", u_if.hi, 32'hFFFF_FFFE);
        run_op("div_neg7", AluDiv, 32'hFFFF_FFF9, 32'd2);
        check("div_neg7_lo_const", u_if.lo, 32'hFFFF_FFFD);
        check("div_neg7_hi_const", u_if.hi, 32'hFFFF_FFFF);
        run_op("divu_100_7", AluDivu, 32'd100, 32'd7);
        run_op("divu_by0", AluDivu, 32'd5, 32'd0);
        run_op("div_ovf", AluDiv, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo_const", u_if.lo, 32'h8000_0000);
        run_op("div_neg_by0", AluDiv, 32'hFFFF_FF00, 32'd0);
        run_op("bad_opcode", 5'd7, 32'hDEAD_BEEF, 32'd3);

        // MTHI held while Busy: ignored until the first non-busy edge.
        @(negedge clk);
        u_if.instr_valid      = 1'b1;
        u_if.spc_reg_write_en = 1'b1;
        u_if.alu_op           = AluDivu;
        u_if.src_a            = 32'd1000;
        u_if.src_b            = 32'd3;
        @(posedge clk);
        #1;
        u_if.alu_op = AluMthi;
        u_if.src_a  = 32'h0000_1234;
        cyc = 0;
        while (u_if.busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(posedge clk);
            #1;
        end
        check("held_busy_cycles", cyc, 33);
        model_apply(AluDivu, 32'd1000, 32'd3);
        check("held_div_hi", u_if.hi, m_hi);
        check("held_div_lo", u_if.lo, m_lo);
        @(posedge clk);
        #1;
        u_if.instr_valid = 1'b0;
        model_apply(AluMthi, 32'h0000_1234, 32'd0);
        check("held_mthi_hi", u_if.hi, 32'h0000_1234);
        check("held_mthi_lo", u_if.lo, m_lo);

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            run_op($sformatf("rand%0d", i), ops[$urandom_range(0, 5)], ra, rb);
        end

        // Asynchronous reset mid-divide, then a fresh divide.
        @(negedge clk);
        u_if.instr_valid      = 1'b1;
        u_if.spc_reg_write_en = 1'b1;
        u_if.alu_op           = AluDiv;
        u_if.src_a            = 32'h7654_3210;
        u_if.src_b            = 32'd13;
        @(posedge clk);
        #1;
        u_if.instr_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        m_hi = '0;
        m_lo = '0;
        check("async_rst_busy", {31'd0, u_if.busy}, 32'd0);
        check("async_rst_hi", u_if.hi, m_hi);
        check("async_rst_lo", u_if.lo, m_lo);
        @(negedge clk);
        rst = 1'b0;
        run_op("divu_9_3", AluDivu, 32'd9, 32'd3);
        check("divu_9_3_lo_const", u_if.lo, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_cpu_hilo_muldiv.md
# mips_cpu_hilo_muldiv

HI/LO special-register unit for the MIPS CPU, directly downstream of the control decoder. It consumes the decoder's `CtrlALUOp` and `CtrlSpcRegWriteEn` outputs with the rs/rt register values. It executes MULT/MULTU in one cycle, DIV/DIVU as a multi-cycle iterative divide, and MTHI/MTLO as direct writes. It presents HI/LO to the register-file write-back mux (MemtoReg selects 3/4) and drives a `Busy` stall to the datapath.

## Interface
- `DIV_CYCLES`, default 32: number of divide iterations. Fixed at 32 for 32-bit operands; other values are unsupported.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `InstrValid`  in  1  the current instruction is issued this cycle (pipeline not stalled, not flushed).
- `CtrlSpcRegWriteEn`  in  1  from decoder; the instruction targets HI/LO.
- `CtrlALUOp`  in  5  from decoder; relevant codes: MUL=2, MULU=22, DIV=3, DIVU=23, MTHI=24, MTLO=25.
- `SrcA`  in  32  rs value (dividend, multiplicand, MTHI/MTLO data).
- `SrcB`  in  32  rt value (divisor, multiplier).
- `Hi`  out  32  HI register.
- `Lo`  out  32  LO register.
- `Busy`  out  1  divide in progress; the datapath must stall any MFHI/MFLO/HI-LO-writing instruction while this is high.

## Operation
- An op is issued when `InstrValid & CtrlSpcRegWriteEn & ~Busy`. Any other `CtrlALUOp` value with the enable high is ignored.
- An op presented while `Busy`=1 is ignored; the CPU holds it until `Busy` falls.
- MUL: {Hi,Lo} <= sext64(SrcA) * sext64(SrcB). MULU: the same with zero-extension. Full 64-bit product.
- MTHI: Hi <= SrcA, Lo unchanged. MTLO: Lo <= SrcA, Hi unchanged.
- DIV/DIVU: latch the operand magnitudes (|x| for DIV, raw for DIVU), the signedness flag, the quotient sign (SrcA[31]^SrcB[31]) and the remainder sign (SrcA[31]). Then run a restoring shift-subtract, one quotient bit per cycle, MSB first, on a 33-bit partial remainder.
- Sign fix (DIV only): negate the quotient if the quotient sign is set; negate the remainder if the dividend was negative. Lo <= quotient, Hi <= remainder.
- 0x80000000 / 0xFFFFFFFF (DIV): Lo=0x80000000, Hi=0. No trap.
- Divide by zero (either signedness): sign fix is bypassed; Lo=0xFFFFFFFF, Hi=SrcA as latched. No trap.
- State machine:
  - IDLE -> DIV on a divide issue.
  - DIV: 5-bit counter 0..31; -> FIX when the counter reaches 31.
  - FIX -> IDLE, writing Hi/Lo.
- `Busy` is a registered output, high exactly when the state is not IDLE.

## Timing
- Reset (asynchronous, immediate): Hi=0, Lo=0, Busy=0, state=IDLE, counter=0. A divide in flight is discarded; nothing is written.
- MUL/MULU/MTHI/MTLO: Hi/Lo are valid after the issue edge (latency 1). `Busy` stays low.
- DIV/DIVU issued at edge E:
  - Iterations occur at edges E+1..E+32.
  - FIX writes Hi/Lo at edge E+33.
  - `Busy` is high for the 33 cycles between E and E+33 and low after E+33.
- Hi/Lo hold their old values throughout a divide. An MFHI issued in the same cycle as an earlier MTHI is a datapath hazard and is not resolved here; the outputs are registered only, with no bypass.
- Back-to-back ops: a new issue is accepted in the first cycle `Busy` is low, including the cycle directly after FIX.

## Structure
- Shared package `mips_cpu_pkg`: ALU-op enum (MUL, MULU, DIV, DIVU, MTHI, MTLO codes, shared with the decoder and ALU), and the state enum {IDLE, DIV, FIX}.
- One sub-module, `mips_cpu_divider_core`:
  - 32-cycle unsigned restoring divider.
  - Ports: start, dividend, divisor, done, quotient, remainder.
  - Signedness and sign fix stay in the top level.

## Test plan
- MUL, SrcA=0xFFFFFFFD (-3), SrcB=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1 after one edge; `Busy` never rises.
- MULU, SrcA=SrcB=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- DIV, SrcA=0xFFFFFFF9 (-7), SrcB=2 -> `Busy` high 33 cycles, then Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Hi/Lo are unchanged until the E+33 edge.
- DIVU 100/7 -> Lo=0x0000000E, Hi=0x00000002. DIVU 5/0 -> Lo=0xFFFFFFFF, Hi=0x00000005. DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Issue MTHI 0x1234 during a divide (held while `Busy`) -> ignored until `Busy` falls. When re-presented after FIX, it sets Hi=0x1234 and leaves the divide's Lo intact.
- Assert `reset` 10 cycles into a divide -> `Busy`=0 and Hi=Lo=0 without waiting for a clock edge. A fresh DIVU 9/3 after release gives Lo=3, Hi=0.
